pe_shared_memory: RTL and testbench



---
 rtl/pe_shared_memory_if.sv | 52 +++++
 rtl/pe_shared_memory.sv | 123 ++++++++++++
 tb/tb_pe_shared_memory.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_shared_memory_if.sv
// Bus bundle for pe_shared_memory: host config port plus per-PE fetch, data and DMA lanes.
// The master side drives requests and the slave side (the memory) drives grants and responses.
interface pe_shared_memory_if #(
  parameter int NUM_PE = 3
);
  logic                 i_conf_rden;
  logic                 i_conf_wren;
  logic [31:0]          i_conf_addr;
  logic [31:0]          i_conf_wdata;
  logic [31:0]          o_conf_rdata;
  logic [3:0]           i_conf_en;
  logic [NUM_PE-1:0]    i_instr_req;
  logic [NUM_PE*32-1:0] i_instr_addr;
  logic [NUM_PE*32-1:0] o_instr_rdata;
  logic [NUM_PE-1:0]    o_instr_rvalid;
  logic [NUM_PE-1:0]    o_instr_gnt;
  logic [NUM_PE-1:0]    i_data_req;
  logic [NUM_PE*32-1:0] i_data_addr;
  logic [NUM_PE-1:0]    i_data_we;
  logic [NUM_PE*4-1:0]  i_data_be;
  logic [NUM_PE*32-1:0] i_data_wdata;
  logic [NUM_PE*32-1:0] o_data_rdata;
  logic [NUM_PE-1:0]    o_data_rvalid;
  logic [NUM_PE-1:0]    o_data_gnt;
  logic [NUM_PE-1:0]    i_dma_rden;
  logic [NUM_PE-1:0]    i_dma_wren;
  logic [NUM_PE*32-1:0] i_dma_addr;
  logic [NUM_PE*32-1:0] i_dma_wdata;
  logic [NUM_PE*32-1:0] o_dma_rdata;
  logic [NUM_PE-1:0]    o_dma_rvalid;
  logic [NUM_PE-1:0]    o_dma_gnt;

  modport master (
    output i_conf_rden, i_conf_wren, i_conf_addr, i_conf_wdata, i_conf_en,
    output i_instr_req, i_instr_addr,
    output i_data_req, i_data_addr, i_data_we, i_data_be, i_data_wdata,
    output i_dma_rden, i_dma_wren, i_dma_addr, i_dma_wdata,
    input  o_conf_rdata, o_instr_rdata, o_instr_rvalid, o_instr_gnt,
    input  o_data_rdata, o_data_rvalid, o_data_gnt,
    input  o_dma_rdata, o_dma_rvalid, o_dma_gnt
  );

  modport slave (
    input  i_conf_rden, i_conf_wren, i_conf_addr, i_conf_wdata, i_conf_en,
    input  i_instr_req, i_instr_addr,
    input  i_data_req, i_data_addr, i_data_we, i_data_be, i_data_wdata,
    input  i_dma_rden, i_dma_wren, i_dma_addr, i_dma_wdata,
    output o_conf_rdata, o_instr_rdata, o_instr_rvalid, o_instr_gnt,
    output o_data_rdata, o_data_rvalid, o_data_gnt,
    output o_dma_rdata, o_dma_rvalid, o_dma_gnt
  );
endinterface

// File: rtl/pe_shared_memory.sv
// Per-PE private dual-port banks: port A serves fetch and host config, port B serves core data and DMA.
// Define DMA_PORT_EN to enable the DMA path; otherwise DMA outputs are tied to zero.
module pe_shared_memory #(
  parameter int NUM_PE = 3,
  parameter int MEM_AW = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pe_shared_memory_if.slave bus
);
  localparam int DEPTH = 1 << MEM_AW;
  localparam int SW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [31:0] mem [NUM_PE][DEPTH];

  logic [NUM_PE-1:0] conf_act;
  logic [NUM_PE-1:0] instr_gnt;
  logic [NUM_PE-1:0] dma_rd;
  logic [NUM_PE-1:0] dma_wr;
  logic [MEM_AW-1:0] conf_idx;
  logic [MEM_AW-1:0] instr_idx [NUM_PE];
  logic [MEM_AW-1:0] data_idx  [NUM_PE];
  logic [MEM_AW-1:0] dma_idx   [NUM_PE];
  logic              conf_wr;
  logic              conf_rd;
  logic [SW-1:0]     conf_sel;

  logic [NUM_PE-1:0]    instr_rvalid_q;
  logic [NUM_PE*32-1:0] instr_rdata_q;
  logic [NUM_PE-1:0]    data_rvalid_q;
  logic [NUM_PE*32-1:0] data_rdata_q;
  logic [31:0]          conf_rdata_q;
`ifdef DMA_PORT_EN
  logic [NUM_PE-1:0]    dma_rvalid_q;
  logic [NUM_PE*32-1:0] dma_rdata_q;
`endif

  // Descending loop leaves conf_sel on the lowest selected bank.
  always_comb begin
    conf_wr  = bus.i_conf_wren;
    conf_idx = bus.i_conf_addr[MEM_AW-1:0];
    conf_sel = '0;
    for (int p = NUM_PE - 1; p >= 0; p--) begin
      conf_act[p]  = bus.i_conf_en[p] & (bus.i_conf_rden | bus.i_conf_wren);
      if (bus.i_conf_en[p]) conf_sel = SW'(p);
      instr_gnt[p] = bus.i_instr_req[p] & ~conf_act[p];
      instr_idx[p] = bus.i_instr_addr[p*32+2 +: MEM_AW];
      data_idx[p]  = bus.i_data_addr[p*32+2 +: MEM_AW];
      dma_idx[p]   = bus.i_dma_addr[p*32 +: MEM_AW];
`ifdef DMA_PORT_EN
      dma_wr[p] = bus.i_dma_wren[p] & ~bus.i_data_req[p];
      dma_rd[p] = bus.i_dma_rden[p] & ~bus.i_dma_wren[p] & ~bus.i_data_req[p];
`else
      dma_wr[p] = 1'b0;
      dma_rd[p] = 1'b0;
`endif
    end
    conf_rd = bus.i_conf_rden & ~bus.i_conf_wren & (|conf_act);
  end

  assign bus.o_instr_gnt    = instr_gnt;
  assign bus.o_instr_rvalid = instr_rvalid_q;
  assign bus.o_instr_rdata  = instr_rdata_q;
  assign bus.o_data_gnt     = bus.i_data_req;
  assign bus.o_data_rvalid  = data_rvalid_q;
  assign bus.o_data_rdata   = data_rdata_q;
  assign bus.o_conf_rdata   = conf_rdata_q;
`ifdef DMA_PORT_EN
  assign bus.o_dma_gnt      = ~bus.i_data_req;
  assign bus.o_dma_rvalid   = dma_rvalid_q;
  assign bus.o_dma_rdata    = dma_rdata_q;
`else
  assign bus.o_dma_gnt      = '0;
  assign bus.o_dma_rvalid   = '0;
  assign bus.o_dma_rdata    = '0;
`endif

  // Storage is never reset; data and DMA never write in the same cycle since DMA yields to data.
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < NUM_PE; p++) begin
      if (conf_act[p] && conf_wr) mem[p][conf_idx] <= bus.i_conf_wdata;
      if (bus.i_data_req[p] && bus.i_data_we[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.i_data_be[p*4+b]) mem[p][data_idx[p]][b*8 +: 8] <= bus.i_data_wdata[p*32+b*8 +: 8];
        end
      end
      if (dma_wr[p]) mem[p][dma_idx[p]] <= bus.i_dma_wdata[p*32 +: 32];
    end
  end

  // Reads sample the array before this edge's writes land, giving read-first collisions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_rvalid_q <= '0;
      instr_rdata_q  <= '0;
      data_rvalid_q  <= '0;
      data_rdata_q   <= '0;
      conf_rdata_q   <= '0;
`ifdef DMA_PORT_EN
      dma_rvalid_q   <= '0;
      dma_rdata_q    <= '0;
`endif
    end else begin
      instr_rvalid_q <= instr_gnt;
      data_rvalid_q  <= bus.i_data_req;
`ifdef DMA_PORT_EN
      dma_rvalid_q   <= dma_rd;
`endif
      for (int p = 0; p < NUM_PE; p++) begin
        if (instr_gnt[p]) instr_rdata_q[p*32 +: 32] <= mem[p][instr_idx[p]];
        if (bus.i_data_req[p]) data_rdata_q[p*32 +: 32] <= mem[p][data_idx[p]];
`ifdef DMA_PORT_EN
        if (dma_rd[p]) dma_rdata_q[p*32 +: 32] <= mem[p][dma_idx[p]];
`endif
      end
      if (conf_rd) conf_rdata_q <= mem[conf_sel][conf_idx];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.i_conf_addr, bus.i_conf_en, bus.i_instr_addr, bus.i_data_addr,
                         bus.i_dma_addr, bus.i_dma_rden, bus.i_dma_wren, bus.i_dma_wdata, dma_rd};
endmodule

// File: tb/tb_pe_shared_memory.sv
// Scoreboard bench for pe_shared_memory: directed scenarios plus random traffic checked
// against an array-based reference model of the banks.
module tb_pe_shared_memory;
  localparam int NUM_PE = 3;
  localparam int MEM_AW = 14;
  localparam int DEPTH  = 1 << MEM_AW;
`ifdef DMA_PORT_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pe_shared_memory_if #(.NUM_PE(NUM_PE)) bus ();

  pe_shared_memory #(.NUM_PE(NUM_PE), .MEM_AW(MEM_AW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic [31:0] ref_mem [NUM_PE][DEPTH];
  exp_t        instr_q [NUM_PE][$];
  exp_t        data_q  [NUM_PE][$];
  exp_t        dma_q   [NUM_PE][$];
  exp_t        conf_q  [$];
  logic [31:0] conf_model = '0;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic setIdle();
    bus.i_conf_rden  = 1'b0;
    bus.i_conf_wren  = 1'b0;
    bus.i_conf_addr  = '0;
    bus.i_conf_wdata = '0;
    bus.i_conf_en    = '0;
    bus.i_instr_req  = '0;
    bus.i_instr_addr = '0;
    bus.i_data_req   = '0;
    bus.i_data_addr  = '0;
    bus.i_data_we    = '0;
    bus.i_data_be    = '0;
    bus.i_data_wdata = '0;
    bus.i_dma_rden   = '0;
    bus.i_dma_wren   = '0;
    bus.i_dma_addr   = '0;
    bus.i_dma_wdata  = '0;
  endtask

  function automatic int coreWord(input logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'(a[MEM_AW-1:0]);
  endfunction

  function automatic logic [31:0] coreAddr(input int w);
    logic [31:0] a;
    a = $urandom;
    a[MEM_AW+1:2] = MEM_AW'(w);
    return a;
  endfunction

  function automatic logic [31:0] wordAddr(input int w);
    logic [31:0] a;
    a = $urandom;
    a[MEM_AW-1:0] = MEM_AW'(w);
    return a;
  endfunction

  // Called just after a rising edge with this cycle's inputs driven; predicts, then advances one cycle.
  task automatic applyStimulus();
    exp_t e;
    bit   conf_on, hit, ig, dreq;
    int   sel;
    #1;
    conf_on = bus.i_conf_rden | bus.i_conf_wren;
    for (int p = 0; p < NUM_PE; p++) begin
      hit  = bus.i_conf_en[p] & conf_on;
      ig   = bus.i_instr_req[p] & ~hit;
      dreq = bus.i_data_req[p];
      checkOutput($sformatf("instr_gnt[%0d]", p), 128'(bus.o_instr_gnt[p]), 128'(ig));
      checkOutput($sformatf("data_gnt[%0d]", p), 128'(bus.o_data_gnt[p]), 128'(dreq));
      checkOutput($sformatf("dma_gnt[%0d]", p), 128'(bus.o_dma_gnt[p]), 128'(DMA_EN & ~dreq));
      e.cyc = cyc + 1;
      if (ig) begin
        e.data = ref_mem[p][coreWord(bus.i_instr_addr[p*32 +: 32])];
        e.chk  = 1'b1;
        instr_q[p].push_back(e);
      end
      if (dreq) begin
        e.data = ref_mem[p][coreWord(bus.i_data_addr[p*32 +: 32])];
        e.chk  = !bus.i_data_we[p];
        data_q[p].push_back(e);
      end
      if (DMA_EN && !dreq && bus.i_dma_rden[p] && !bus.i_dma_wren[p]) begin
        e.data = ref_mem[p][wordIdx(bus.i_dma_addr[p*32 +: 32])];
        e.chk  = 1'b1;
        dma_q[p].push_back(e);
      end
    end
    if (bus.i_conf_rden && !bus.i_conf_wren) begin
      sel = -1;
      for (int p = NUM_PE - 1; p >= 0; p--) if (bus.i_conf_en[p]) sel = p;
      if (sel >= 0) begin
        e.cyc  = cyc + 1;
        e.chk  = 1'b1;
        e.data = ref_mem[sel][wordIdx(bus.i_conf_addr)];
        conf_q.push_back(e);
      end
    end
    for (int p = 0; p < NUM_PE; p++) begin
      if (bus.i_conf_wren && bus.i_conf_en[p]) ref_mem[p][wordIdx(bus.i_conf_addr)] = bus.i_conf_wdata;
      if (bus.i_data_req[p] && bus.i_data_we[p]) begin
        for (int b = 0; b < 4; b++)
          if (bus.i_data_be[p*4+b])
            ref_mem[p][coreWord(bus.i_data_addr[p*32 +: 32])][b*8 +: 8] = bus.i_data_wdata[p*32+b*8 +: 8];
      end
      if (DMA_EN && !bus.i_data_req[p] && bus.i_dma_wren[p])
        ref_mem[p][wordIdx(bus.i_dma_addr[p*32 +: 32])] = bus.i_dma_wdata[p*32 +: 32];
    end
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic flushModel();
    for (int p = 0; p < NUM_PE; p++) begin
      instr_q[p].delete();
      data_q[p].delete();
      dma_q[p].delete();
    end
    conf_q.delete();
    conf_model = '0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_instr_rvalid"}, 128'(bus.o_instr_rvalid), 128'(0));
    checkOutput({tag, "_instr_rdata"},  128'(bus.o_instr_rdata),  128'(0));
    checkOutput({tag, "_data_rvalid"},  128'(bus.o_data_rvalid),  128'(0));
    checkOutput({tag, "_data_rdata"},   128'(bus.o_data_rdata),   128'(0));
    checkOutput({tag, "_dma_rvalid"},   128'(bus.o_dma_rvalid),   128'(0));
    checkOutput({tag, "_dma_rdata"},    128'(bus.o_dma_rdata),    128'(0));
    checkOutput({tag, "_conf_rdata"},   128'(bus.o_conf_rdata),   128'(0));
  endtask

  // Monitor: every falling edge, each stream must show rvalid exactly when its oldest entry is due.
  always @(negedge clk) begin
    exp_t e;
    bit   due;
    if (mon_en) begin
      for (int p = 0; p < NUM_PE; p++) begin
        due = (instr_q[p].size() > 0) && (instr_q[p][0].cyc <= cyc);
        checkOutput($sformatf("instr_rvalid[%0d]", p), 128'(bus.o_instr_rvalid[p]), 128'(due));
        if (due) begin
          e = instr_q[p].pop_front();
          checkOutput($sformatf("instr_rdata[%0d]", p), 128'(bus.o_instr_rdata[p*32 +: 32]), 128'(e.data));
        end
        due = (data_q[p].size() > 0) && (data_q[p][0].cyc <= cyc);
        checkOutput($sformatf("data_rvalid[%0d]", p), 128'(bus.o_data_rvalid[p]), 128'(due));
        if (due) begin
          e = data_q[p].pop_front();
          if (e.chk) checkOutput($sformatf("data_rdata[%0d]", p), 128'(bus.o_data_rdata[p*32 +: 32]), 128'(e.data));
        end
        due = (dma_q[p].size() > 0) && (dma_q[p][0].cyc <= cyc);
        checkOutput($sformatf("dma_rvalid[%0d]", p), 128'(bus.o_dma_rvalid[p]), 128'(due));
        if (due) begin
          e = dma_q[p].pop_front();
          checkOutput($sformatf("dma_rdata[%0d]", p), 128'(bus.o_dma_rdata[p*32 +: 32]), 128'(e.data));
        end
      end
      if (conf_q.size() > 0 && conf_q[0].cyc <= cyc) begin
        e = conf_q.pop_front();
        conf_model = e.data;
      end
      checkOutput("conf_rdata", 128'(bus.o_conf_rdata), 128'(conf_model));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    setIdle();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    $display("[TB] preload words 0..15 of every bank");
    for (int w = 0; w < 16; w++) begin
      for (int p = 0; p < NUM_PE; p++) begin
        bus.i_conf_wren  = 1'b1;
        bus.i_conf_en    = 4'(1 << p);
        bus.i_conf_addr  = wordAddr(w);
        bus.i_conf_wdata = $urandom;
        applyStimulus();
      end
    end

    $display("[TB] conf broadcast write and selective read");
    bus.i_conf_wren = 1'b1; bus.i_conf_en = 4'b0011; bus.i_conf_addr = 32'd5; bus.i_conf_wdata = 32'hDEADBEEF;
    applyStimulus();
    bus.i_conf_rden = 1'b1; bus.i_conf_en = 4'b0010; bus.i_conf_addr = 32'd5;
    applyStimulus();
    bus.i_conf_rden = 1'b1; bus.i_conf_en = 4'b0100; bus.i_conf_addr = 32'd5;
    applyStimulus();
    bus.i_conf_rden = 1'b1; bus.i_conf_wren = 1'b1; bus.i_conf_en = 4'b1000; bus.i_conf_addr = 32'd5;
    applyStimulus();

    $display("[TB] fetch, back-to-back fetch, fetch blocked by conf");
    bus.i_instr_req[0] = 1'b1; bus.i_instr_addr[31:0] = 32'h14;
    applyStimulus();
    bus.i_instr_req[0] = 1'b1; bus.i_instr_addr[31:0] = 32'h18;
    applyStimulus();
    bus.i_instr_req[0] = 1'b1; bus.i_instr_addr[31:0] = 32'h14;
    bus.i_conf_rden = 1'b1; bus.i_conf_en = 4'b0001; bus.i_conf_addr = 32'd6;
    applyStimulus();

    $display("[TB] byte-masked data write then read");
    bus.i_conf_wren = 1'b1; bus.i_conf_en = 4'b0010; bus.i_conf_addr = 32'd9; bus.i_conf_wdata = 32'hAABBCCDD;
    applyStimulus();
    bus.i_data_req[1] = 1'b1; bus.i_data_we[1] = 1'b1; bus.i_data_be[7:4] = 4'b0101;
    bus.i_data_addr[63:32] = 32'h24; bus.i_data_wdata[63:32] = 32'h11223344;
    applyStimulus();
    bus.i_data_req[1] = 1'b1; bus.i_data_addr[63:32] = 32'h24;
    applyStimulus();

    $display("[TB] data versus DMA arbitration");
    bus.i_data_req[1] = 1'b1; bus.i_data_addr[63:32] = 32'h0;
    bus.i_dma_wren[1] = 1'b1; bus.i_dma_addr[63:32] = 32'd7; bus.i_dma_wdata[63:32] = 32'h55;
    applyStimulus();
    bus.i_dma_wren[1] = 1'b1; bus.i_dma_addr[63:32] = 32'd7; bus.i_dma_wdata[63:32] = 32'h55;
    applyStimulus();
    bus.i_dma_rden[1] = 1'b1; bus.i_dma_addr[63:32] = 32'd7;
    applyStimulus();
    bus.i_dma_rden[1] = 1'b1; bus.i_dma_wren[1] = 1'b1; bus.i_dma_addr[63:32] = 32'd8; bus.i_dma_wdata[63:32] = 32'h66;
    applyStimulus();
    bus.i_data_req[1] = 1'b1; bus.i_data_addr[63:32] = 32'h1C;
    applyStimulus();

    $display("[TB] address wrap and read-first collisions");
    bus.i_data_req[2] = 1'b1; bus.i_data_addr[95:64] = 32'((DEPTH + 5) * 4);
    applyStimulus();
    bus.i_instr_req[0] = 1'b1; bus.i_instr_addr[31:0] = 32'hC;
    bus.i_data_req[0] = 1'b1; bus.i_data_we[0] = 1'b1; bus.i_data_be[3:0] = 4'hF;
    bus.i_data_addr[31:0] = 32'hC; bus.i_data_wdata[31:0] = 32'hCAFEF00D;
    applyStimulus();
    bus.i_instr_req[0] = 1'b1; bus.i_instr_addr[31:0] = 32'hC;
    bus.i_conf_rden = 1'b1; bus.i_conf_en = 4'b0010; bus.i_conf_addr = 32'd4;
    bus.i_data_req[1] = 1'b1; bus.i_data_we[1] = 1'b1; bus.i_data_be[7:4] = 4'hF;
    bus.i_data_addr[63:32] = 32'h10; bus.i_data_wdata[63:32] = 32'h0BADC0DE;
    applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      bus.i_conf_wren  = ($urandom_range(7) == 0);
      bus.i_conf_rden  = ($urandom_range(7) == 0);
      bus.i_conf_en    = 4'($urandom);
      bus.i_conf_addr  = wordAddr($urandom_range(15));
      bus.i_conf_wdata = $urandom;
      for (int p = 0; p < NUM_PE; p++) begin
        bus.i_instr_req[p]           = $urandom_range(1) == 1;
        bus.i_instr_addr[p*32 +: 32] = coreAddr($urandom_range(15));
        bus.i_data_req[p]            = $urandom_range(1) == 1;
        bus.i_data_we[p]             = !bus.i_conf_wren && ($urandom_range(1) == 1);
        bus.i_data_be[p*4 +: 4]      = 4'($urandom);
        bus.i_data_addr[p*32 +: 32]  = coreAddr($urandom_range(15));
        bus.i_data_wdata[p*32 +: 32] = $urandom;
        bus.i_dma_rden[p]            = $urandom_range(1) == 1;
        bus.i_dma_wren[p]            = !bus.i_conf_wren && ($urandom_range(2) == 0);
        bus.i_dma_addr[p*32 +: 32]   = wordAddr($urandom_range(15));
        bus.i_dma_wdata[p*32 +: 32]  = $urandom;
      end
      applyStimulus();
    end

    $display("[TB] reset during pending reads");
    bus.i_data_req[0] = 1'b1; bus.i_data_addr[31:0] = 32'h8;
    bus.i_instr_req[2] = 1'b1; bus.i_instr_addr[95:64] = 32'h8;
    bus.i_conf_rden = 1'b1; bus.i_conf_en = 4'b0001; bus.i_conf_addr = 32'd2;
    applyStimulus();
    #1 rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    checkResetOutputs("midreset");
    flushModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    bus.i_data_req[0] = 1'b1; bus.i_data_addr[31:0] = 32'h8;
    bus.i_instr_req[1] = 1'b1; bus.i_instr_addr[63:32] = 32'h24;
    applyStimulus();
    bus.i_conf_rden = 1'b1; bus.i_conf_en = 4'b0001; bus.i_conf_addr = 32'd5;
    applyStimulus();

    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < NUM_PE; p++)
      checkOutput($sformatf("outstanding[%0d]", p),
                  128'(instr_q[p].size() + data_q[p].size() + dma_q[p].size()), 128'(0));
    checkOutput("outstanding_conf", 128'(conf_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
